// File: rtl/alu_exec_pkg.sv
// ----------------------------------------------------------------------------
// alu_exec_pkg
//   Shared definitions for the execute-stage ALU (alu_exec_unit):
//     - alu_op_e     : 4-bit operation codes from the ALU control decoder
//     - alu_state_e  : control FSM states (IDLE, SHIFT)
//     - is_shift_op  : true for SRL / SLL / SRA
//   Codes 0100 and 1101-1111 are deliberately absent from the enum; the ALU
//   maps them to a zero result.
// ----------------------------------------------------------------------------
package alu_exec_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_AND   = 4'b0000,
      OP_OR    = 4'b0001,
      OP_XOR   = 4'b0010,
      OP_ADD   = 4'b0011,
      OP_EQ    = 4'b0101,
      OP_NE    = 4'b0110,
      OP_LT    = 4'b0111,
      OP_GE    = 4'b1000,
      OP_SRL   = 4'b1001,
      OP_SLL   = 4'b1010,
      OP_SRA   = 4'b1011,
      OP_PASSB = 4'b1100
   } alu_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } alu_state_e;

   function automatic logic is_shift_op(alu_op_e op);
      return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// ----------------------------------------------------------------------------
// alu_shift_iter
//   Iterative shifter, one bit position per clock.
//   Ports:
//     clk, reset  : clock, asynchronous active-low reset
//     load        : capture src/shamt/dir/arith and start shifting
//     shamt       : shift amount (load with a non-zero value only)
//     dir         : 1 = left shift, 0 = right shift
//     arith       : right shift fills with the sign bit (ignored for left)
//     src         : value to shift
//     done        : the current cycle performs the final shift step
//     result      : value after the current step; valid when done=1
//   done/result are combinational so the caller can register the final value
//   on the same edge as the last step, giving a latency of exactly shamt.
// ----------------------------------------------------------------------------
module alu_shift_iter #(
   parameter int DATA_WIDTH = 32,
   parameter int SHW        = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [SHW-1:0]        shamt,
   input  logic                  dir,
   input  logic                  arith,
   input  logic [DATA_WIDTH-1:0] src,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] shifted;
   logic [SHW-1:0]        cnt_q;
   logic                  dir_q;
   logic                  arith_q;

   always_comb begin
      shifted = data_q;
      if (dir_q) begin
         shifted = {data_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
         shifted = {arith_q & data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         arith_q <= 1'b0;
      end else if (load) begin
         data_q  <= src;
         cnt_q   <= shamt;
         dir_q   <= dir;
         arith_q <= arith;
      end else if (cnt_q != '0) begin
         data_q <= shifted;
         cnt_q  <= cnt_q - CNT_ONE;
      end
   end

   assign done   = (cnt_q == CNT_ONE);
   assign result = shifted;

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU between the ID/EX and EX/MEM registers. Takes one
//   operation per input handshake and returns a registered result plus a
//   registered Zero flag. Logic, add, compare and PASSB complete in one cycle;
//   shifts use the iterative shifter (shamt cycles) unless the barrel build is
//   selected.
//   Ports:
//     clk, reset          : clock, asynchronous active-low reset
//     in_valid / in_ready : input handshake for Operation, SrcA, SrcB
//     Operation           : 4-bit op code (alu_op_e)
//     SrcA, SrcB          : operands; shift amount is SrcB[SHW-1:0]
//     out_valid/out_ready : output handshake for ALUResult, Zero
//     ALUResult, Zero     : result and (result == 0), registered together
//     busy                : iterative shift in progress (FSM in SHIFT)
//   Configuration macro:
//     ALU_BARREL_SHIFT_EN : shifts use a single-cycle barrel shifter, the
//                           SHIFT state is never entered and busy is 0.
//                           Results are identical; only latency differs.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. A producer holds valid and its payload stable until that edge;
//   ready may change freely. out_valid/ALUResult/Zero hold while
//   out_valid && !out_ready, and in_ready is low then, so no result is lost.
// ----------------------------------------------------------------------------
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero,
   output logic                  busy
);

   localparam int SHW = $clog2(DATA_WIDTH);

   alu_op_e               op;
   logic [SHW-1:0]        shamt;
   logic                  accept;
   logic                  start_shift;
   logic                  sh_done;
   logic [DATA_WIDTH-1:0] sh_result;
   logic [DATA_WIDTH-1:0] comb_result;
   alu_state_e            state_q;
   alu_state_e            state_d;

   assign op     = alu_op_e'(Operation);
   assign shamt  = SrcB[SHW-1:0];
   assign accept = in_valid && in_ready;

   // Single-cycle datapath. In the iterative build a shift reaching this path
   // always has shamt == 0, so its result is simply SrcA.
   always_comb begin
      comb_result = '0;
      case (op)
         OP_AND:   comb_result = SrcA & SrcB;
         OP_OR:    comb_result = SrcA | SrcB;
         OP_XOR:   comb_result = SrcA ^ SrcB;
         OP_ADD:   comb_result = SrcA + SrcB;
         OP_EQ:    comb_result[0] = (SrcA == SrcB);
         OP_NE:    comb_result[0] = (SrcA != SrcB);
         OP_LT:    comb_result[0] = ($signed(SrcA) <  $signed(SrcB));
         OP_GE:    comb_result[0] = ($signed(SrcA) >= $signed(SrcB));
         OP_PASSB: comb_result = SrcB;
`ifdef ALU_BARREL_SHIFT_EN
         OP_SRL:   comb_result = SrcA >> shamt;
         OP_SLL:   comb_result = SrcA << shamt;
         OP_SRA:   comb_result = $unsigned($signed(SrcA) >>> shamt);
`else
         OP_SRL, OP_SLL, OP_SRA: comb_result = SrcA;
`endif
         default:  comb_result = '0;
      endcase
   end

`ifdef ALU_BARREL_SHIFT_EN
   assign start_shift = 1'b0;
   assign sh_done     = 1'b0;
   assign sh_result   = '0;
`else
   assign start_shift = accept && is_shift_op(op) && (shamt != '0);

   alu_shift_iter #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHW        (SHW)
   ) u_shift (
      .clk    (clk),
      .reset  (reset),
      .load   (start_shift),
      .shamt  (shamt),
      .dir    (op == OP_SLL),
      .arith  (op == OP_SRA),
      .src    (SrcA),
      .done   (sh_done),
      .result (sh_result)
   );
`endif

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_shift) state_d = ST_SHIFT;
         ST_SHIFT: if (sh_done)     state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs. busy is the SHIFT state made visible outside the unit.
   always_comb begin
      in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready);
`ifdef ALU_BARREL_SHIFT_EN
      busy     = 1'b0;
`else
      busy     = (state_q == ST_SHIFT);
`endif
   end

   // Result register. A new result (single-cycle accept or final shift step)
   // takes priority over clearing out_valid, which gives the no-bubble
   // handshake-and-accept on one edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         ALUResult <= '0;
         Zero      <= 1'b1;
      end else if (accept && !start_shift) begin
         out_valid <= 1'b1;
         ALUResult <= comb_result;
         Zero      <= (comb_result == '0);
      end else if ((state_q == ST_SHIFT) && sh_done) begin
         out_valid <= 1'b1;
         ALUResult <= sh_result;
         Zero      <= (sh_result == '0);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
//   Bench for alu_exec_unit (DATA_WIDTH = 32). Honors ALU_BARREL_SHIFT_EN for
//   the expected shift latency.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;

   localparam int W = 32;

   localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_XOR = 4'b0010,
                          C_ADD = 4'b0011, C_EQ = 4'b0101, C_NE = 4'b0110,
                          C_LT  = 4'b0111, C_GE = 4'b1000, C_SRL = 4'b1001,
                          C_SLL = 4'b1010, C_SRA = 4'b1011, C_PASSB = 4'b1100;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    Operation;
   logic [W-1:0]  SrcA;
   logic [W-1:0]  SrcB;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  ALUResult;
   logic          Zero;
   logic          busy;

   always #5 clk = ~clk;

   alu_exec_unit #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .Zero      (Zero),
      .busy      (busy)
   );

   // ---------------- scoreboard state ----------------
   logic [W:0] exp_q[$];          // {Zero, ALUResult}
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_pops   = 0;
   logic       rand_bp  = 1'b0;
   logic       held_v   = 1'b0;
   logic [W:0] held_val;

   task automatic check_word(input string name, input logic [W:0] act, input logic [W:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      logic [W-1:0] r;
      logic [4:0]   s5;
      int           s;
      int           sa;
      int           sb;
      s5 = b[4:0];
      s  = int'(s5);
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         C_AND:   r = a & b;
         C_OR:    r = a | b;
         C_XOR:   r = a ^ b;
         C_ADD:   r = a + b;
         C_EQ:    r = (a == b) ? 32'd1 : 32'd0;
         C_NE:    r = (a != b) ? 32'd1 : 32'd0;
         C_LT:    r = (sa <  sb) ? 32'd1 : 32'd0;
         C_GE:    r = (sa >= sb) ? 32'd1 : 32'd0;
         C_SRL:   r = a >> s;
         C_SLL:   r = a << s;
         C_SRA:   r = (a >> s) | (a[W-1] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         C_PASSB: r = b;
         default: r = '0;
      endcase
      return {(r == '0), r};
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int waited);
      in_valid  = 1'b1;
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      waited    = 0;
      #2;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         #2;
         waited++;
      end
      if (!in_ready) begin
         n_checks++;
         $display("FAIL accept_timeout: in_ready low for %0d cycles", waited);
         @(negedge clk);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(model(op, a, b));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            held_v = 1'b0;
         end else begin
            if (held_v) begin
               check_bit("hold_valid", out_valid, 1'b1);
               check_word("hold_data", {Zero, ALUResult}, held_val);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_result: got %h expected none", {Zero, ALUResult});
               end else begin
                  check_word("result", {Zero, ALUResult}, exp_q.pop_front());
                  n_pops++;
               end
               held_v = 1'b0;
            end else if (out_valid) begin
               held_v   = 1'b1;
               held_val = {Zero, ALUResult};
            end else begin
               held_v = 1'b0;
            end
         end
      end
   end

   // Random back-pressure
   initial begin : backpressure
      forever begin
         @(negedge clk);
         if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Watchdog
   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main stimulus ----------------
   initial begin : main
      int w;
      int busy_cnt;
      int k;
      int cnt;
      int pops0;
      int wsum;
      int exp_lat;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   op;

      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      Operation = '0;
      SrcA      = '0;
      SrcB      = '0;
      wait_cycles(3);
      #1;
      check_bit("rst_in_ready", in_ready, 1'b1);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_word("rst_result", {Zero, ALUResult}, {1'b1, 32'h0});
      check_bit("rst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // ADD wrap to zero
      out_ready = 1'b1;
      send(C_ADD, 32'hFFFF_FFFF, 32'h1, w);
      check_bit("add_wrap_valid", out_valid, 1'b1);
      check_word("add_wrap", {Zero, ALUResult}, {1'b1, 32'h0});

      // Signed compares
      send(C_LT, 32'hFFFF_FFFE, 32'h1, w);
      check_word("lt_signed", {Zero, ALUResult}, {1'b0, 32'h1});
      send(C_GE, 32'hFFFF_FFFE, 32'h1, w);
      check_word("ge_signed", {Zero, ALUResult}, {1'b1, 32'h0});

      // SRA latency
`ifdef ALU_BARREL_SHIFT_EN
      exp_lat = 0;
`else
      exp_lat = 4;
`endif
      send(C_SRA, 32'h8000_0000, 32'd4, w);
      busy_cnt = 0;
      k = 0;
      while (!out_valid && k < 100) begin
         if (busy) begin
            busy_cnt++;
            check_bit("sra_in_ready_busy", in_ready, 1'b0);
         end
         @(negedge clk);
         k++;
      end
      check_int("sra_busy_cycles", busy_cnt, exp_lat);
      check_word("sra_result", {Zero, ALUResult}, {1'b0, 32'hF800_0000});
      @(negedge clk);

      // Hold under back-pressure, then no-bubble release
      out_ready = 1'b0;
      send(C_XOR, 32'h0000_F0F0, 32'h0000_0FF0, w);
      for (int i = 0; i < 5; i++) begin
         check_bit("hold_out_valid", out_valid, 1'b1);
         check_word("hold_xor", {Zero, ALUResult}, {1'b0, 32'h0000_FF00});
         check_bit("hold_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(C_ADD, 32'd5, 32'd7, w);
      check_int("release_no_bubble", w, 0);
      check_bit("release_valid", out_valid, 1'b1);
      check_word("release_result", {Zero, ALUResult}, {1'b0, 32'd12});
      @(negedge clk);

      // Reset during a long shift
      send(C_SLL, 32'h1, 32'd31, w);
      wait_cycles(9);
      reset = 1'b0;
      #1;
      exp_q.delete();
      check_bit("midrst_out_valid", out_valid, 1'b0);
      check_word("midrst_result", {Zero, ALUResult}, {1'b1, 32'h0});
      check_bit("midrst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check_bit("midrst_in_ready", in_ready, 1'b1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (out_valid) cnt++;
      end
      check_int("no_stale_result", cnt, 0);

      // Stream of 8 ADDs
      pops0 = n_pops;
      wsum  = 0;
      cnt   = 0;
      for (int i = 0; i < 8; i++) begin
         send(C_ADD, $urandom, $urandom, w);
         wsum += w;
         if (out_valid) cnt++;
      end
      check_int("stream_waits", wsum, 0);
      check_int("stream_valid_cycles", cnt, 8);
      #3;
      check_int("stream_results", n_pops - pops0, 8);
      @(negedge clk);

      // Random ops with random back-pressure
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = 32'($urandom_range(0, 40));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 3));
         send(op, a, b, w);
      end
      rand_bp = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_int("drain_empty", exp_q.size(), 0);
      wait_cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
